spi_slave_gen: RTL and testbench

//  Parametrised SPI slave front-end: deserialises MOSI frames of CMD_W+DATA_W bits into rx_data
//  for the register/RAM wrapper; serialises read data back on MISO. Samples one bit per clk while
//  SS_n low. Adds over the fixed 10-bit slave: width/bit-order params, tx_ready, frame_err, and a

---
 rtl/spi_pkg.sv | 27 ++
 rtl/spi_tx_serializer.sv | 75 +++++++
 rtl/spi_slave_gen.sv | 146 ++++++++++++++
 tb/tb_spi_slave_gen.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave front-end: FSM state encoding,
// op-select values and the command-field codes seen by the wrapper.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CHK_CMD   = 3'd1,
        ST_WRITE     = 3'd2,
        ST_READ_ADD  = 3'd3,
        ST_READ_DATA = 3'd4
    } spi_state_e;

    // First MOSI bit after SS_n falls selects write vs read handling.
    localparam logic OP_WRITE = 1'b0;
    localparam logic OP_READ  = 1'b1;

    // Command-field codes for the default 2-bit command width.
    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    function automatic logic is_capture(spi_state_e s);
        return (s == ST_WRITE) || (s == ST_READ_ADD) || (s == ST_READ_DATA);
    endfunction

endpackage

// File: rtl/spi_tx_serializer.sv
// Parallel-load MISO serializer: one bit per clk after a load, in either
// bit order, with an abort that silences the line on the next edge.
module spi_tx_serializer #(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              abort_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              miso_o,
    output logic              pending_o
);

    localparam int CNT_W = $clog2(DATA_W);

    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] shifted;
    logic              out_bit;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign out_bit = shreg_q[DATA_W-1];
            assign shifted = {shreg_q[DATA_W-2:0], 1'b0};
        end else begin : g_lsb_first
            assign out_bit = shreg_q[0];
            assign shifted = {1'b0, shreg_q[DATA_W-1:1]};
        end
    endgenerate

    // cnt_q is the number of bits still to follow the one currently driven.
    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        if (abort_i) begin
            shreg_d = '0;
            cnt_d   = '0;
            busy_d  = 1'b0;
        end else if (load_i) begin
            shreg_d = data_i;
            cnt_d   = CNT_W'(DATA_W - 1);
            busy_d  = 1'b1;
        end else if (busy_q) begin
            if (cnt_q == '0) begin
                shreg_d = '0;
                busy_d  = 1'b0;
            end else begin
                shreg_d = shifted;
                cnt_d   = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    // Gating with busy keeps MISO low outside the shift window, including
    // straight after an asynchronous reset.
    assign miso_o    = busy_q & out_bit;
    assign pending_o = busy_q && (cnt_q != '0);

endmodule

// File: rtl/spi_slave_gen.sv
// Parametrised SPI slave front-end: command FSM, MOSI deserialiser with a
// held rx_data word, and read-data handshake into the MISO serializer.
module spi_slave_gen
    import spi_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int CMD_W     = 2,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    SS_n,
    input  logic                    MOSI,
    input  logic                    tx_valid,
    input  logic [DATA_W-1:0]       tx_data,
    output logic                    rx_valid,
    output logic [CMD_W+DATA_W-1:0] rx_data,
    output logic                    MISO,
    output logic                    tx_ready,
    output logic                    frame_err
);

    localparam int FRAME_W = CMD_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] PENULT_CNT = CNT_W'(FRAME_W - 1);

    spi_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [FRAME_W-2:0]   shreg_q, shreg_d;
    logic [FRAME_W-1:0]   rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 rd_seen_q, rd_seen_d;
    logic                 tx_ready_q, tx_ready_d;
    logic                 frame_err_q, frame_err_d;
    logic                 load;
    logic                 tx_pending;
    logic                 frame_done;
    logic                 capturing;

    assign load       = tx_valid && tx_ready_q;
    assign frame_done = (cnt_q == LAST_CNT);
    assign capturing  = is_capture(state_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        rd_seen_d   = rd_seen_q;
        tx_ready_d  = tx_ready_q;
        frame_err_d = 1'b0;

        if (SS_n) begin
            // Deselect always wins, even over the final capture bit.
            state_d     = ST_IDLE;
            cnt_d       = '0;
            shreg_d     = '0;
            tx_ready_d  = 1'b0;
            frame_err_d = (capturing && !frame_done) || tx_pending;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_CHK_CMD;
                end
                ST_CHK_CMD: begin
                    if (MOSI == OP_WRITE) begin
                        state_d = ST_WRITE;
                    end else if (rd_seen_q) begin
                        state_d = ST_READ_DATA;
                    end else begin
                        state_d = ST_READ_ADD;
                    end
                end
                ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
                    if (!frame_done) begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        shreg_d = {shreg_q[FRAME_W-3:0], MOSI};
                        if (cnt_q == PENULT_CNT) begin
                            rx_data_d  = {shreg_q, MOSI};
                            rx_valid_d = 1'b1;
                            if (state_q == ST_READ_ADD) begin
                                rd_seen_d = 1'b1;
                            end else if (state_q == ST_READ_DATA) begin
                                rd_seen_d = 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            // Ready opens the cycle after a READ_DATA frame's rx_valid pulse
            // and closes on the single load it admits.
            if (load) begin
                tx_ready_d = 1'b0;
            end else if (rx_valid_q && (state_q == ST_READ_DATA)) begin
                tx_ready_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            rd_seen_q   <= 1'b0;
            tx_ready_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rd_seen_q   <= rd_seen_d;
            tx_ready_q  <= tx_ready_d;
            frame_err_q <= frame_err_d;
        end
    end

    spi_tx_serializer #(
        .DATA_W    (DATA_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_tx_serializer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (load),
        .abort_i   (SS_n),
        .data_i    (tx_data),
        .miso_o    (MISO),
        .pending_o (tx_pending)
    );

    assign rx_valid  = rx_valid_q;
    assign rx_data   = rx_data_q;
    assign tx_ready  = tx_ready_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave_gen.sv
// Scoreboard bench for spi_slave_gen: an 8-bit MSB-first instance and a
// 16-bit LSB-first instance, directed frames with hand-computed responses.
module tb_spi_slave_gen;

    localparam int K_RX  = 0;
    localparam int K_ERR = 1;
    localparam int K_TX  = 2;

    typedef struct {
        int          kind;
        logic [17:0] data;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ss8, mosi8, txv8, rxv8, miso8, txr8, ferr8;
    logic [7:0]  txd8;
    logic [9:0]  rxd8;
    logic        ss16, mosi16, txv16, rxv16, miso16, txr16, ferr16;
    logic [15:0] txd16;
    logic [17:0] rxd16;

    ev_t q8[$];
    ev_t q16[$];
    int  vectors     = 0;
    int  miscompares = 0;

    always #5 clk = ~clk;

    spi_slave_gen #(.DATA_W(8), .CMD_W(2), .MSB_FIRST(1'b1)) dut8 (
        .clk(clk), .rst_n(rst_n), .SS_n(ss8), .MOSI(mosi8),
        .tx_valid(txv8), .tx_data(txd8), .rx_valid(rxv8), .rx_data(rxd8),
        .MISO(miso8), .tx_ready(txr8), .frame_err(ferr8)
    );

    spi_slave_gen #(.DATA_W(16), .CMD_W(2), .MSB_FIRST(1'b0)) dut16 (
        .clk(clk), .rst_n(rst_n), .SS_n(ss16), .MOSI(mosi16),
        .tx_valid(txv16), .tx_data(txd16), .rx_valid(rxv16), .rx_data(rxd16),
        .MISO(miso16), .tx_ready(txr16), .frame_err(ferr16)
    );

    task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic push(input bit big, input int kind, input logic [17:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        if (big) q16.push_back(e);
        else     q8.push_back(e);
    endtask

    task automatic observe(input bit big, input int kind, input logic [17:0] data);
        ev_t   e;
        string tag;
        tag = big ? "dut16" : "dut8";
        $display("%0t %s event kind=%0d data=%h", $time, tag, kind, data);
        if ((big && q16.size() == 0) || (!big && q8.size() == 0)) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_unexpected: actual kind %0d data %h required no event", tag, kind, data);
            return;
        end
        if (big) e = q16.pop_front();
        else     e = q8.pop_front();
        check({tag, "_kind"}, 18'(kind), 18'(e.kind));
        check({tag, "_data"}, data, e.data);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ss(input bit big, input logic v);
        if (big) ss16 = v;
        else     ss8  = v;
    endtask

    task automatic set_mosi(input bit big, input logic v);
        if (big) mosi16 = v;
        else     mosi8  = v;
    endtask

    // Select, op bit, then nbits of word MSB first; SS_n stays low afterwards.
    task automatic frame(input bit big, input logic op, input logic [17:0] word, input int nbits);
        int fw;
        fw = big ? 18 : 10;
        set_ss(big, 1'b0);
        tick();
        set_mosi(big, op);
        tick();
        for (int i = 0; i < nbits; i++) begin
            set_mosi(big, word[fw-1-i]);
            tick();
        end
        if (nbits == fw) begin
            if (big) check("dut16_rx_latency", 18'(rxv16), 18'h1);
            else     check("dut8_rx_latency", 18'(rxv8), 18'h1);
        end
    endtask

    task automatic ss_high(input bit big);
        set_ss(big, 1'b1);
        set_mosi(big, 1'b0);
        tick();
    endtask

    // Monitor for the 8-bit instance: frames, errors and MISO words.
    initial begin
        int          cnt;
        logic [15:0] seq;
        cnt = 0;
        seq = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cnt = 0;
            end else begin
                if (rxv8)  observe(1'b0, K_RX, 18'(rxd8));
                if (ferr8) observe(1'b0, K_ERR, 18'h0);
                if (cnt > 0) begin
                    seq = {seq[14:0], miso8};
                    cnt--;
                    if (cnt == 0)  observe(1'b0, K_TX, {10'h0, seq[7:0]});
                    else if (ss8)  cnt = 0;
                end else begin
                    check("dut8_miso_idle", 18'(miso8), 18'h0);
                end
                if (txv8 && txr8 && !ss8) begin
                    cnt = 8;
                    seq = '0;
                end
            end
        end
    end

    // Monitor for the 16-bit instance.
    initial begin
        int          cnt;
        logic [15:0] seq;
        cnt = 0;
        seq = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cnt = 0;
            end else begin
                if (rxv16)  observe(1'b1, K_RX, rxd16);
                if (ferr16) observe(1'b1, K_ERR, 18'h0);
                if (cnt > 0) begin
                    seq = {seq[14:0], miso16};
                    cnt--;
                    if (cnt == 0)   observe(1'b1, K_TX, {2'b00, seq});
                    else if (ss16)  cnt = 0;
                end else begin
                    check("dut16_miso_idle", 18'(miso16), 18'h0);
                end
                if (txv16 && txr16 && !ss16) begin
                    cnt = 16;
                    seq = '0;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        ss8 = 1'b1;  mosi8 = 1'b0;  txv8 = 1'b0;  txd8 = 8'h00;
        ss16 = 1'b1; mosi16 = 1'b0; txv16 = 1'b0; txd16 = 16'h0000;
        tick();
        tick();
        check("rst_rx_valid", 18'(rxv8), 18'h0);
        check("rst_rx_data", 18'(rxd8), 18'h0);
        check("rst_miso", 18'(miso8), 18'h0);
        check("rst_tx_ready", 18'(txr8), 18'h0);
        check("rst_frame_err", 18'(ferr8), 18'h0);
        check("rst_rx_data16", rxd16, 18'h0);
        rst_n = 1'b1;
        tick();

        // Write frame, with tx_valid asserted while tx_ready is low.
        push(1'b0, K_RX, 18'h0A5);
        txv8 = 1'b1;
        txd8 = 8'hFF;
        frame(1'b0, 1'b0, 18'h0A5, 10);
        tick();
        check("wr_tx_ready", 18'(txr8), 18'h0);
        tick();
        txv8 = 1'b0;
        ss_high(1'b0);

        // Abort after five write bits: frame_err, rx_data held.
        push(1'b0, K_ERR, 18'h0);
        frame(1'b0, 1'b0, 18'h3C3, 5);
        ss_high(1'b0);
        tick();
        check("abort_rx_data", 18'(rxd8), 18'h0A5);

        // Read pair with readback of 8'hC3 MSB first.
        push(1'b0, K_RX, 18'h230);
        frame(1'b0, 1'b1, 18'h230, 10);
        ss_high(1'b0);
        push(1'b0, K_RX, 18'h3FF);
        frame(1'b0, 1'b1, 18'h3FF, 10);
        check("rd_tx_ready_early", 18'(txr8), 18'h0);
        tick();
        check("rd_tx_ready", 18'(txr8), 18'h1);
        push(1'b0, K_TX, 18'h000C3);
        txv8 = 1'b1;
        txd8 = 8'hC3;
        tick();
        txv8 = 1'b0;
        check("rd_tx_ready_after_load", 18'(txr8), 18'h0);
        check("rd_first_miso", 18'(miso8), 18'h1);
        repeat (8) tick();
        check("rd_miso_after", 18'(miso8), 18'h0);
        ss_high(1'b0);

        // rd_addr_seen was cleared: next read frame is an address frame.
        push(1'b0, K_RX, 18'h155);
        frame(1'b0, 1'b1, 18'h155, 10);
        tick();
        check("rd_seen_cleared", 18'(txr8), 18'h0);
        ss_high(1'b0);

        // SS_n rise on the 10th capture edge.
        push(1'b0, K_ERR, 18'h0);
        frame(1'b0, 1'b0, 18'h3FF, 9);
        ss_high(1'b0);
        check("late_abort_rx_data", 18'(rxd8), 18'h155);

        // SS_n rise during an unfinished MISO shift.
        push(1'b0, K_RX, 18'h2AA);
        frame(1'b0, 1'b1, 18'h2AA, 10);
        tick();
        txv8 = 1'b1;
        txd8 = 8'hA5;
        tick();
        txv8 = 1'b0;
        tick();
        tick();
        push(1'b0, K_ERR, 18'h0);
        ss_high(1'b0);
        tick();

        // Reset in the middle of a readback.
        push(1'b0, K_RX, 18'h0F0);
        frame(1'b0, 1'b1, 18'h0F0, 10);
        ss_high(1'b0);
        push(1'b0, K_RX, 18'h1E1);
        frame(1'b0, 1'b1, 18'h1E1, 10);
        tick();
        txv8 = 1'b1;
        txd8 = 8'hFF;
        tick();
        txv8 = 1'b0;
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_miso", 18'(miso8), 18'h0);
        check("rstmid_tx_ready", 18'(txr8), 18'h0);
        check("rstmid_rx_data", 18'(rxd8), 18'h0);
        check("rstmid_rx_valid", 18'(rxv8), 18'h0);
        ss8 = 1'b1;
        mosi8 = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Reset cleared rd_addr_seen: read frame is an address frame.
        push(1'b0, K_RX, 18'h3FF);
        frame(1'b0, 1'b1, 18'h3FF, 10);
        tick();
        check("rstmid_rd_seen", 18'(txr8), 18'h0);
        ss_high(1'b0);

        // 16-bit LSB-first instance: read pair, readback of 16'h0001.
        push(1'b1, K_RX, 18'h12345);
        frame(1'b1, 1'b1, 18'h12345, 18);
        ss_high(1'b1);
        push(1'b1, K_RX, 18'h3FFFF);
        frame(1'b1, 1'b1, 18'h3FFFF, 18);
        tick();
        check("w16_tx_ready", 18'(txr16), 18'h1);
        push(1'b1, K_TX, 18'h08000);
        txv16 = 1'b1;
        txd16 = 16'h0001;
        tick();
        txv16 = 1'b0;
        check("w16_first_miso", 18'(miso16), 18'h1);
        repeat (16) tick();
        check("w16_miso_after", 18'(miso16), 18'h0);
        ss_high(1'b1);

        repeat (3) tick();
        check("q8_drained", 18'(q8.size()), 18'h0);
        check("q16_drained", 18'(q16.size()), 18'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
